// File: rtl/ibex_register_file_mp_if.sv
// ibex_register_file_mp_if
//   Bundle between the register file and its users. The WB stage drives the
//   write ports. The decoder and operand muxes drive the read addresses and
//   consume the read data.
//   master : user side. Drives addresses, write data, enables and the dummy flag.
//   slave  : register-file side. Drives rdata_o, wr_collision_o and err_o.
//   Signals:
//     dummy_instr_id_i  current ID instruction is a dummy instruction
//     raddr_i           read addresses, 5 bits per port
//     rdata_o           read data, DataWidth bits per port
//     waddr_i/wdata_i   write address/data, packed per write port
//     we_i              per-port write enable
//     wr_collision_o    a staged write pair targeted the same address
//     err_o             per-read-port parity error
interface ibex_register_file_mp_if #(
  parameter int NumRead   = 2,
  parameter int NumWrite  = 1,
  parameter int DataWidth = 32
);
  logic                          dummy_instr_id_i;
  logic [NumRead*5-1:0]          raddr_i;
  logic [NumRead*DataWidth-1:0]  rdata_o;
  logic [NumWrite*5-1:0]         waddr_i;
  logic [NumWrite*DataWidth-1:0] wdata_i;
  logic [NumWrite-1:0]           we_i;
  logic                          wr_collision_o;
  logic [NumRead-1:0]            err_o;

  modport master (
    output dummy_instr_id_i, raddr_i, waddr_i, wdata_i, we_i,
    input  rdata_o, wr_collision_o, err_o
  );

  modport slave (
    input  dummy_instr_id_i, raddr_i, waddr_i, wdata_i, we_i,
    output rdata_o, wr_collision_o, err_o
  );
endinterface

// File: rtl/ibex_register_file_mp.sv
// ibex_register_file_mp
//   This is a multi-port integer register file. Writes pass through a
//   capture stage (wq) and are committed on the following edge. Reads are
//   combinational. When WriteBypass=1, reads can forward data from the
//   capture stage. Register x0 reads as zero. When DummyInstructions=1,
//   x0 has a writable shadow that is only visible while dummy_instr_id_i
//   is set.
//   Optional build macro RF_PARITY_EN: adds an even-parity bit to every
//   storage word, the shadow r0 and the capture stage. err_o flags a
//   mismatch on the source that was read. When the macro is undefined,
//   err_o is 0.
//   Ports:
//     clk_int  register file clock
//     rst_ni   asynchronous active-low reset
//     bus      ibex_register_file_mp_if slave modport
module ibex_register_file_mp #(
  parameter bit RV32E             = 1'b0,
  parameter int DataWidth         = 32,
  parameter int NumRead           = 2,
  parameter int NumWrite          = 1,
  parameter bit WriteBypass       = 1'b1,
  parameter bit DummyInstructions = 1'b0
) (
  input logic                    clk_int,
  input logic                    rst_ni,
  ibex_register_file_mp_if.slave bus
);
  localparam int AW       = RV32E ? 4 : 5;
  localparam int NumWords = 2 ** AW;

  logic [DataWidth-1:0] mem [NumWords];
  logic [DataWidth-1:0] shadow_r0;
  logic [NumWrite-1:0]  wq_vld;
  logic [NumWrite-1:0]  wq_dummy;
  logic [AW-1:0]        wq_addr [NumWrite];
  logic [DataWidth-1:0] wq_data [NumWrite];
  logic                 wr_collision_q;
  logic                 collision_d;
`ifdef RF_PARITY_EN
  logic [NumWords-1:0]  mem_par;
  logic [NumWrite-1:0]  wq_par;
  logic                 shadow_par;
`endif

  generate
    if (NumWrite == 2) begin : g_coll
      // Compare only the AW address bits, because aliased addresses hit the same word.
      assign collision_d = bus.we_i[0] & bus.we_i[1] &
                           (bus.waddr_i[0 +: AW] == bus.waddr_i[5 +: AW]);
    end else begin : g_no_coll
      assign collision_d = 1'b0;
    end
  endgenerate

  always_ff @(posedge clk_int or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < NumWords; i++) mem[i] <= '0;
      for (int w = 0; w < NumWrite; w++) begin
        wq_addr[w] <= '0;
        wq_data[w] <= '0;
      end
      wq_vld         <= '0;
      wq_dummy       <= '0;
      shadow_r0      <= '0;
      wr_collision_q <= 1'b0;
`ifdef RF_PARITY_EN
      mem_par    <= '0;
      wq_par     <= '0;
      shadow_par <= 1'b0;
`endif
    end else begin
      // Commit: the loop runs from the highest port down to port 0, so on an address tie port 0 is written last and wins.
      for (int w = NumWrite - 1; w >= 0; w--) begin
        if (wq_vld[w]) begin
          if (wq_addr[w] != '0) begin
            mem[wq_addr[w]] <= wq_data[w];
`ifdef RF_PARITY_EN
            mem_par[wq_addr[w]] <= wq_par[w];
`endif
          end else if (DummyInstructions && wq_dummy[w]) begin
            shadow_r0 <= wq_data[w];
`ifdef RF_PARITY_EN
            shadow_par <= wq_par[w];
`endif
          end
        end
      end
      // Capture
      for (int w = 0; w < NumWrite; w++) begin
        wq_vld[w] <= bus.we_i[w];
        if (bus.we_i[w]) begin
          wq_addr[w]  <= bus.waddr_i[5*w +: AW];
          wq_data[w]  <= bus.wdata_i[DataWidth*w +: DataWidth];
          wq_dummy[w] <= bus.dummy_instr_id_i;
`ifdef RF_PARITY_EN
          wq_par[w] <= ^bus.wdata_i[DataWidth*w +: DataWidth];
`endif
        end
      end
      wr_collision_q <= collision_d;
    end
  end

  logic [NumRead*DataWidth-1:0] rdata_c;
  logic [NumRead-1:0]           err_c;
  logic [AW-1:0]                ra;
  logic [DataWidth-1:0]         sel_data;
  logic                         sel_par;
  logic                         sel_chk;

  always_comb begin
    rdata_c  = '0;
    err_c    = '0;
    ra       = '0;
    sel_data = '0;
    sel_par  = 1'b0;
    sel_chk  = 1'b0;
    for (int p = 0; p < NumRead; p++) begin
      ra       = bus.raddr_i[5*p +: AW];
      sel_data = mem[ra];
      sel_par  = 1'b0;
      sel_chk  = 1'b1;
`ifdef RF_PARITY_EN
      sel_par = mem_par[ra];
`endif
      if (ra == '0) begin
        if (DummyInstructions && bus.dummy_instr_id_i) begin
          sel_data = shadow_r0;
`ifdef RF_PARITY_EN
          sel_par = shadow_par;
`endif
        end else begin
          sel_data = '0;
          sel_chk  = 1'b0;
        end
      end else if (WriteBypass) begin
        // Loop from the highest port down to port 0, so port 0 has the final say on the forwarded value.
        for (int w = NumWrite - 1; w >= 0; w--) begin
          if (wq_vld[w] && (wq_addr[w] == ra)) begin
            sel_data = wq_data[w];
`ifdef RF_PARITY_EN
            sel_par = wq_par[w];
`endif
          end
        end
      end
      if (rst_ni) begin
        rdata_c[DataWidth*p +: DataWidth] = sel_data;
`ifdef RF_PARITY_EN
        err_c[p] = sel_chk & ((^sel_data) ^ sel_par);
`else
        err_c[p] = 1'b0 & sel_chk & sel_par;
`endif
      end
    end
  end

  assign bus.rdata_o        = rdata_c;
  assign bus.err_o          = err_c;
  assign bus.wr_collision_o = wr_collision_q;
endmodule
